// File: rtl/neural_layer_engine.sv
// Sequential multiply-accumulate engine for one fully connected layer with saturating outputs.
// Optional build macro NEURAL_LAYER_ENGINE_RELU_EN clamps negative results to zero.
module neural_layer_engine #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned N_IN      = 4,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned FRAC_BITS = 0,
  localparam int unsigned IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned W_AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int unsigned OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [OUT_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IN_AW-1:0]          i_q, i_d;
  logic [OUT_AW-1:0]         n_q, n_d;
  logic                      busy_q, busy_d, done_q, done_d, out_we_q, out_we_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic [IN_AW-1:0]          in_addr_q, in_addr_d;
  logic [W_AW-1:0]           w_addr_q, w_addr_d;
  logic [OUT_AW-1:0]         out_addr_q, out_addr_d;

  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   acc_sum_c, shifted_c;
  logic [DATA_W-1:0]         sat_c, res_c;
  logic                      last_i, last_n;

  assign last_i    = (i_q == IN_AW'(N_IN - 1));
  assign last_n    = (n_q == OUT_AW'(N_OUT - 1));
  assign prod_c    = $signed(in_data) * $signed(w_data);
  assign acc_sum_c = acc_q + ACC_W'(prod_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Abort wins over every transition out of RUN/DRAIN/WRITE, including entry into WRITE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (abort) state_d = S_IDLE; else if (last_i) state_d = S_DRAIN;
      S_DRAIN: state_d = abort ? S_IDLE : S_WRITE;
      S_WRITE: if (abort) state_d = S_IDLE; else state_d = last_n ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_comb begin
    acc_d = acc_q;
    i_d   = i_q;
    n_d   = n_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        acc_d = '0;
        i_d   = '0;
        n_d   = '0;
      end
      S_RUN: begin
        if (i_q != '0) acc_d = acc_sum_c;
        i_d = last_i ? '0 : i_q + IN_AW'(1);
      end
      S_DRAIN: acc_d = acc_sum_c;
      S_WRITE: begin
        acc_d = '0;
        i_d   = '0;
        if (!last_n) n_d = n_q + OUT_AW'(1);
      end
      default: ;
    endcase

    shifted_c = acc_d >>> FRAC_BITS;
    if (shifted_c > SAT_MAX)      sat_c = DATA_W'(SAT_MAX);
    else if (shifted_c < SAT_MIN) sat_c = DATA_W'(SAT_MIN);
    else                          sat_c = DATA_W'(shifted_c);
`ifdef NEURAL_LAYER_ENGINE_RELU_EN
    res_c = sat_c[DATA_W-1] ? '0 : sat_c;
`else
    res_c = sat_c;
`endif

    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    out_we_d   = (state_d == S_WRITE);
    out_addr_d = out_we_d ? n_d : '0;
    out_data_d = out_we_d ? res_c : out_data_q;
    in_addr_d  = (state_d == S_RUN) ? i_d : '0;
    w_addr_d   = (state_d == S_RUN) ? W_AW'(32'(n_d) * N_IN + 32'(i_d)) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      i_q        <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
    end else begin
      acc_q      <= acc_d;
      i_q        <= i_d;
      n_q        <= n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_we_q   <= out_we_d;
      out_data_q <= out_data_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_we   = out_we_q;
  assign out_data = out_data_q;
  assign in_addr  = in_addr_q;
  assign w_addr   = w_addr_q;
  assign out_addr = out_addr_q;

endmodule

// File: tb/tb_neural_layer_engine.sv
// Scoreboard bench for neural_layer_engine: two instances (FRAC_BITS 0 and 2) sharing one memory image.
module tb_neural_layer_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 20;
  localparam int unsigned NI = 4;
  localparam int unsigned NO = 2;
  localparam int unsigned IA = 2;
  localparam int unsigned WA = 3;
  localparam int unsigned OA = 1;

`ifdef NEURAL_LAYER_ENGINE_RELU_EN
  localparam int RELU = 1;
`else
  localparam int RELU = 0;
`endif

  typedef struct packed {
    logic [OA-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, start_f, abort_f;
  logic          busy, done, out_we, busy_f, done_f, out_we_f;
  logic [IA-1:0] in_addr, in_addr_f;
  logic [WA-1:0] w_addr, w_addr_f;
  logic [OA-1:0] out_addr, out_addr_f;
  logic [DW-1:0] in_data, w_data, out_data, in_data_f, w_data_f, out_data_f;

  logic signed [DW-1:0] act [NI];
  logic signed [DW-1:0] wgt [NI*NO];

  exp_t exp_q[$];
  exp_t exp_f[$];
  int   chk_cnt, pass_cnt, done_cnt, done_f_cnt;

  neural_layer_engine #(.DATA_W(DW), .ACC_W(AW), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(0)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .out_addr(out_addr), .out_data(out_data), .out_we(out_we));

  neural_layer_engine #(.DATA_W(DW), .ACC_W(AW), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(2)) dut_f (
    .clk(clk), .reset(rst_n), .start(start_f), .abort(abort_f), .busy(busy_f), .done(done_f),
    .in_addr(in_addr_f), .in_data(in_data_f), .w_addr(w_addr_f), .w_data(w_data_f),
    .out_addr(out_addr_f), .out_data(out_data_f), .out_we(out_we_f));

  // One-cycle read latency memories
  always @(posedge clk) begin
    in_data   <= act[in_addr];
    w_data    <= wgt[w_addr];
    in_data_f <= act[in_addr_f];
    w_data_f  <= wgt[w_addr_f];
  end

  function automatic int post(input int v);
    return (RELU != 0 && v < 0) ? 0 : v;
  endfunction

  task automatic push(input bit to_f, input int a, input int d);
    exp_t e;
    e.addr = OA'(a);
    e.data = DW'(d);
    if (to_f) exp_f.push_back(e);
    else      exp_q.push_back(e);
  endtask

  // Advance one clock and retire any write strobes against the scoreboards.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (out_we === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_write unexpected write addr=%0d data=%0d", out_addr, $signed(out_data));
      end else begin
        e = exp_q.pop_front();
        if (out_addr !== e.addr || out_data !== e.data)
          $display("FAIL sb_write got addr=%0d data=%0d want addr=%0d data=%0d",
                   out_addr, $signed(out_data), e.addr, $signed(e.data));
        else pass_cnt++;
      end
    end
    if (out_we_f === 1'b1) begin
      chk_cnt++;
      if (exp_f.size() == 0) begin
        $display("FAIL sb_write_f unexpected write addr=%0d data=%0d", out_addr_f, $signed(out_data_f));
      end else begin
        e = exp_f.pop_front();
        if (out_addr_f !== e.addr || out_data_f !== e.data)
          $display("FAIL sb_write_f got addr=%0d data=%0d want addr=%0d data=%0d",
                   out_addr_f, $signed(out_data_f), e.addr, $signed(e.data));
        else pass_cnt++;
      end
    end
    if (done === 1'b1)   done_cnt++;
    if (done_f === 1'b1) done_f_cnt++;
  endtask

  task automatic pulse_and_wait(output int cyc);
    start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      step();
      cyc++;
      start = 1'b0;
      if (done === 1'b1) break;
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) act[i] = DW'(i + 1);
    for (int i = 0; i < 4; i++) wgt[i] = 8'sd1;
    wgt[4] = 8'sd2; wgt[5] = 8'sd0; wgt[6] = 8'sd0; wgt[7] = -8'sd1;
  endtask

  task automatic test_reset();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (out_we !== 1'b0) $display("FAIL reset_we got %b want 0", out_we); else pass_cnt++;
    chk_cnt++; if (out_data !== '0) $display("FAIL reset_data got %0h want 0", out_data); else pass_cnt++;
    chk_cnt++; if (in_addr !== '0 || w_addr !== '0 || out_addr !== '0)
      $display("FAIL reset_addr got %0d/%0d/%0d want 0/0/0", in_addr, w_addr, out_addr); else pass_cnt++;
  endtask

  task automatic test_basic();
    int cyc;
    load_basic();
    push(0, 0, post(10));
    push(0, 1, post(-2));
    pulse_and_wait(cyc);
    chk_cnt++; if (cyc != 13) $display("FAIL basic_latency got %0d want 13", cyc); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL basic_pending got %0d want 0", exp_q.size()); else pass_cnt++;
    step();
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 4; i++) act[i] = 8'sd127;
    for (int i = 0; i < 8; i++) wgt[i] = 8'sd127;
    push(0, 0, 127);
    push(0, 1, 127);
    pulse_and_wait(cyc);
    chk_cnt++; if (cyc != 13) $display("FAIL sat_pos_latency got %0d want 13", cyc); else pass_cnt++;
    step();
    for (int i = 0; i < 8; i++) wgt[i] = -8'sd128;
    push(0, 0, post(-128));
    push(0, 1, post(-128));
    pulse_and_wait(cyc);
    chk_cnt++; if (cyc != 13) $display("FAIL sat_neg_latency got %0d want 13", cyc); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL sat_pending got %0d want 0", exp_q.size()); else pass_cnt++;
    step();
  endtask

  task automatic test_abort();
    int cyc, d0;
    load_basic();
    d0 = done_cnt;
    push(0, 0, post(10));
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    repeat (20) step();
    chk_cnt++; if (done_cnt != d0) $display("FAIL abort_done got %0d want %0d", done_cnt, d0); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL abort_pending got %0d want 0", exp_q.size()); else pass_cnt++;
    push(0, 0, post(10));
    push(0, 1, post(-2));
    pulse_and_wait(cyc);
    chk_cnt++; if (cyc != 13) $display("FAIL abort_restart_latency got %0d want 13", cyc); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_write();
    int d0;
    load_basic();
    d0 = done_cnt;
    push(0, 0, post(10));
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk_cnt++; if (out_we !== 1'b1) $display("FAIL rstw_in_write got %b want 1", out_we); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (out_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstw_ctrl got we=%b busy=%b done=%b want 0/0/0", out_we, busy, done); else pass_cnt++;
    chk_cnt++; if (out_data !== '0 || out_addr !== '0 || in_addr !== '0 || w_addr !== '0)
      $display("FAIL rstw_data got data=%0h addrs=%0d/%0d/%0d want 0", out_data, out_addr, in_addr, w_addr);
    else pass_cnt++;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk_cnt++; if (done_cnt != d0) $display("FAIL rstw_done got %0d want %0d", done_cnt, d0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstw_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_frac_busy_start();
    int cyc, d0;
    for (int i = 0; i < 4; i++) act[i] = 8'sd4;
    for (int i = 0; i < 8; i++) wgt[i] = 8'sd4;
    d0 = done_f_cnt;
    push(1, 0, 16);
    push(1, 1, 16);
    start_f = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      step();
      cyc++;
      start_f = (cyc == 3);
      if (done_f === 1'b1) break;
    end
    chk_cnt++; if (cyc != 13) $display("FAIL frac_latency got %0d want 13", cyc); else pass_cnt++;
    start_f = 1'b1;
    step();
    start_f = 1'b0;
    chk_cnt++; if (busy_f !== 1'b0) $display("FAIL start_in_done busy got %b want 0", busy_f); else pass_cnt++;
    repeat (20) step();
    chk_cnt++; if (done_f_cnt != d0 + 1) $display("FAIL frac_done_count got %0d want %0d", done_f_cnt, d0 + 1);
    else pass_cnt++;
    chk_cnt++; if (exp_f.size() != 0) $display("FAIL frac_pending got %0d want 0", exp_f.size()); else pass_cnt++;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; done_cnt = 0; done_f_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_f = 1'b0; abort_f = 1'b0;
    for (int i = 0; i < 4; i++) act[i] = '0;
    for (int i = 0; i < 8; i++) wgt[i] = '0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_saturation();
    test_abort();
    test_reset_write();
    test_frac_busy_start();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
